ledbits_driver: RTL
===================

// Module: ledbits_driver
// PURPOSE
//   Parametrised LED output driver, successor to the single constant-bit driver.
//   Drives WIDTH LED pins from one of four modes: constant, blink, rotate, bounce.
//   An internal prescaler sets the animation rate.
//   Sits directly between board pins and top-level control (switches or UART decode).
// PARAMETERS
//   WIDTH    4            number of LED outputs; legal range 1..32
//   PATTERN  4'b0101      WIDTH-bit constant used by SET, BLINK and ROTATE
//   DIV      12_000_000   clk cycles per animation tick; must be >= 2 (1 s at 12 MHz)
// PORTS
//   clk    in   1      system clock; all logic on posedge
//   rst    in   1      synchronous reset, active-high
//   en     in   1      1 = prescaler runs; 0 = freeze prescaler and LEDs
//   mode   in   2      00 SET, 01 BLINK, 10 ROTATE, 11 BOUNCE
//   leds   out  WIDTH  registered LED drive
//   tick   out  1      registered one-cycle pulse on each animation step
// BEHAVIOUR
//   - Reset (rst=1 at posedge):
//       leds=0, tick=0, prescaler cnt=0, mode_q=SET, dir=left.
//   - Prescaler:
//       - cnt counts 0..DIV-1 while en=1; holds while en=0.
//       - At cnt==DIV-1 with en=1: cnt wraps to 0 and tick=1 on the next cycle.
//   - Mode load: if mode != mode_q at a posedge (including the first cycle after reset):
//       - mode_q<=mode, cnt<=0, dir<=left, no tick that cycle;
//       - leds<= SET/BLINK/ROTATE: PATTERN; BOUNCE: 1 (bit 0 only).
//       - Load happens regardless of en.
//       - Latency from mode change to new leds: 1 cycle.
//   - Step on tick (mode stable, en=1, cnt==DIV-1), applied on the same edge tick is set:
//       - SET: leds held at PATTERN; tick still pulses.
//       - BLINK: leds <= (leds==0) ? PATTERN : 0.
//       - ROTATE: leds <= {leds[WIDTH-2:0], leds[WIDTH-1]}. WIDTH=1: unchanged.
//       - BOUNCE: single hot bit moves one position per tick.
//           - dir=left: bit shifts up; on reaching bit WIDTH-1, dir flips to right.
//           - dir=right: bit shifts down; on reaching bit 0, dir flips to left.
//           - End bits are lit for exactly one tick; period is 2*(WIDTH-1) ticks.
//           - WIDTH=1: leds stays 1.
//   - en=0: leds and cnt frozen and tick=0. A mode change still reloads (see Mode load).
//   - Mode change coinciding with a prescaler wrap: the load wins and no step is taken.
//   - rst has priority over everything, including a mid-animation state.
//   - Outputs are fully registered; there is no combinational path from inputs to outputs.
// TESTING  (bench: WIDTH=4, PATTERN=4'b0101, DIV=4)
//   1. rst=1 for 2 cycles, then en=1, mode=SET
//        -> leds=0000 during reset; leds=0101 one cycle after release, stable for 20 cycles.
//        -> tick pulses every 4 cycles.
//   2. mode=BLINK, en=1
//        -> leds sequence 0101, 0000, 0101, changing every 4 cycles, aligned to tick.
//   3. mode=ROTATE
//        -> leds 0101, 1010, 0101 per tick.
//        -> repeat with PATTERN=4'b0001: 0001, 0010, 0100, 1000, 0001.
//   4. mode=BOUNCE
//        -> leds 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010; period 6 ticks.
//   5. BOUNCE at leds=0100 with dir=left, drop en for 10 cycles
//        -> leds held at 0100 and no tick while en=0.
//        -> on restoring en, next step is 1000 exactly 4 cycles later.
//   6. Assert rst mid-BOUNCE (leds=1000)
//        -> leds=0000 next cycle; after release in BOUNCE, leds=0001 with dir=left.
//        -> switching mode on the wrap cycle gives a load with no extra step.

Source files
------------

// File: rtl/ledbits_driver.sv
// WIDTH-pin LED driver with SET/BLINK/ROTATE/BOUNCE modes stepped by an internal prescaler.
// Mode change reaches the leds after 1 cycle; en=0 freezes the prescaler and the leds; there is no backpressure.
module ledbits_driver #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] PATTERN = WIDTH'(4'b0101),
  parameter int               DIV     = 12_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] leds,
  output logic             tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CMAX = CW'(DIV - 1);

  typedef enum logic [1:0] {
    M_SET    = 2'b00,
    M_BLINK  = 2'b01,
    M_ROTATE = 2'b10,
    M_BOUNCE = 2'b11
  } mode_e;

  mode_e            mode_q, mode_d, mode_in;
  logic             loaded, loaded_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             dir, dir_d;
  logic [WIDTH-1:0] leds_d;
  logic             tick_d;
  logic [WIDTH-1:0] shl, shr;

  assign mode_in = mode_e'(mode);
  assign shl     = leds << 1;
  assign shr     = leds >> 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= M_SET;
      loaded <= 1'b0;
      cnt    <= '0;
      dir    <= 1'b0;
      leds   <= '0;
      tick   <= 1'b0;
    end else begin
      mode_q <= mode_d;
      loaded <= loaded_d;
      cnt    <= cnt_d;
      dir    <= dir_d;
      leds   <= leds_d;
      tick   <= tick_d;
    end
  end

  // 'loaded' forces a load on the first cycle after reset even when mode already reads SET.
  always_comb begin
    mode_d   = mode_q;
    loaded_d = loaded;
    cnt_d    = cnt;
    dir_d    = dir;
    leds_d   = leds;
    tick_d   = 1'b0;
    if (!loaded || (mode_in != mode_q)) begin
      mode_d   = mode_in;
      loaded_d = 1'b1;
      cnt_d    = '0;
      dir_d    = 1'b0;
      leds_d   = (mode_in == M_BOUNCE) ? WIDTH'(1) : PATTERN;
    end else if (en) begin
      if (cnt == CMAX) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        case (mode_q)
          M_SET:    leds_d = PATTERN;
          M_BLINK:  leds_d = (leds == '0) ? PATTERN : '0;
          M_ROTATE: leds_d = shl | (leds >> (WIDTH - 1));
          M_BOUNCE: begin
            if (WIDTH > 1) begin
              if (!dir) begin
                leds_d = shl;
                if (shl[WIDTH-1]) dir_d = 1'b1;
              end else begin
                leds_d = shr;
                if (shr[0]) dir_d = 1'b0;
              end
            end
          end
          default:  leds_d = leds;
        endcase
      end else begin
        cnt_d = cnt + CW'(1);
      end
    end
  end

endmodule
